// File: rtl/shift_left_branch.sv
// shift_left_branch
//   Branch-offset scaler for the 16-bit single-cycle CPU. The sign-extended
//   branch immediate is shifted left by SHIFT bits (halfword -> byte offset)
//   combinationally for the branch-target adder path. A registered stage also
//   forms pc_plus2 + offset for pipelined or debug use.
//
// Ports
//   clk               in   1      rising-edge clock for the registered stage
//   rst_n             in   1      synchronous reset, active-low
//   Shift_Branch      in   WIDTH  sign-extended branch immediate
//   Shift_Branch_out  out  WIDTH  Shift_Branch << SHIFT (logical), combinational
//   shift_carry       out  1      OR of the bits shifted out, combinational
//   sign_change       out  1      MSB differs between input and shifted output
//   in_valid          in   1      latch a branch target this cycle
//   pc_plus2          in   WIDTH  address of the next sequential instruction
//   target_q          out  WIDTH  registered pc_plus2 + Shift_Branch_out
//   target_valid_q    out  1      target_q was updated on the last edge
//   target_wrap_q     out  1      registered carry-out of the target addition
module shift_left_branch #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Shift_Branch,
  output logic [WIDTH-1:0] Shift_Branch_out,
  output logic             shift_carry,
  output logic             sign_change,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pc_plus2,
  output logic [WIDTH-1:0] target_q,
  output logic             target_valid_q,
  output logic             target_wrap_q
);

  logic [WIDTH:0] target_sum;

  // Logical shift: the top SHIFT bits are dropped, zeros fill from the right.
  assign Shift_Branch_out = {Shift_Branch[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
  assign shift_carry      = |Shift_Branch[WIDTH-1 -: SHIFT];
  assign sign_change      = Shift_Branch[WIDTH-1] ^ Shift_Branch_out[WIDTH-1];

  // One extra bit captures the carry-out for target_wrap_q.
  assign target_sum = {1'b0, pc_plus2} + {1'b0, Shift_Branch_out};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q       <= '0;
      target_valid_q <= 1'b0;
      target_wrap_q  <= 1'b0;
    end else if (in_valid) begin
      target_q       <= target_sum[WIDTH-1:0];
      target_valid_q <= 1'b1;
      target_wrap_q  <= target_sum[WIDTH];
    end else begin
      target_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_left_branch.sv
// tb_shift_left_branch
//   Directed-vector bench for shift_left_branch with hand-computed expectations.
module tb_shift_left_branch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Shift_Branch;
  logic [15:0] Shift_Branch_out;
  logic        shift_carry;
  logic        sign_change;
  logic        in_valid;
  logic [15:0] pc_plus2;
  logic [15:0] target_q;
  logic        target_valid_q;
  logic        target_wrap_q;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  shift_left_branch #(.WIDTH(16), .SHIFT(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Shift_Branch     (Shift_Branch),
    .Shift_Branch_out (Shift_Branch_out),
    .shift_carry      (shift_carry),
    .sign_change      (sign_change),
    .in_valid         (in_valid),
    .pc_plus2         (pc_plus2),
    .target_q         (target_q),
    .target_valid_q   (target_valid_q),
    .target_wrap_q    (target_wrap_q)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [15:0] out, input logic carry,
                            input logic sc);
    check({tag, ".out"},   Shift_Branch_out, out);
    check({tag, ".carry"}, {15'b0, shift_carry}, {15'b0, carry});
    check({tag, ".sign"},  {15'b0, sign_change}, {15'b0, sc});
  endtask

  task automatic check_reg(input string tag, input logic [15:0] tq, input logic v,
                           input logic w);
    check({tag, ".target"}, target_q, tq);
    check({tag, ".valid"},  {15'b0, target_valid_q}, {15'b0, v});
    check({tag, ".wrap"},   {15'b0, target_wrap_q},  {15'b0, w});
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    pc_plus2     = 16'h0000;
    Shift_Branch = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reg("reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Combinational shifts
    Shift_Branch = 16'h0001; #10;
    check_comb("t1", 16'h0002, 1'b0, 1'b0);
    Shift_Branch = 16'h8000; #10;
    check_comb("t2", 16'h0000, 1'b1, 1'b1);
    Shift_Branch = 16'hFFFF; #10;
    check_comb("t3", 16'hFFFE, 1'b1, 1'b0);
    Shift_Branch = 16'h4000; #10;
    check_comb("t3b", 16'h8000, 1'b0, 1'b1);

    // Zero input, with rst_n low and high
    rst_n = 1'b0; Shift_Branch = 16'h0000; #10;
    check_comb("t4_rst0", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1; #10;
    check_comb("t4_rst1", 16'h0000, 1'b0, 1'b0);

    // Reset for one edge, then one latched target: 0x0010 + (0x0004<<1) = 0x0018
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; pc_plus2 = 16'h0010; Shift_Branch = 16'h0004;
    @(negedge clk);
    check_reg("t5", 16'h0018, 1'b1, 1'b0);

    // Wrap: 0xFFFE + 0x0004 = 0x1_0002
    pc_plus2 = 16'hFFFE; Shift_Branch = 16'h0002;
    @(negedge clk);
    check_reg("t6", 16'h0002, 1'b1, 1'b1);
    in_valid = 1'b0; pc_plus2 = 16'h1111;
    @(negedge clk);
    check_reg("t6_hold", 16'h0002, 1'b0, 1'b1);
    @(negedge clk);
    check_reg("t6_hold2", 16'h0002, 1'b0, 1'b1);

    // Back-to-back updates: 0x0100 + 0xFFFE = 0x1_00FE, then 0x0002 + 0xFFFE = 0x1_0000,
    // then 0x1234 + 0x0020 = 0x1254
    in_valid = 1'b1; pc_plus2 = 16'h0100; Shift_Branch = 16'hFFFF;
    @(negedge clk);
    check_reg("b2b_0", 16'h00FE, 1'b1, 1'b1);
    pc_plus2 = 16'h0002;
    @(negedge clk);
    check_reg("b2b_1", 16'h0000, 1'b1, 1'b1);
    pc_plus2 = 16'h1234; Shift_Branch = 16'h0010;
    @(negedge clk);
    check_reg("b2b_2", 16'h1254, 1'b1, 1'b0);

    // Mid-stream reset beats in_valid; combinational path keeps tracking
    rst_n = 1'b0; Shift_Branch = 16'hC001;
    @(negedge clk);
    check_reg("mid_rst", 16'h0000, 1'b0, 1'b0);
    check_comb("mid_rst_comb", 16'h8002, 1'b1, 1'b0);

    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reg("post_rst_idle", 16'h0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
